// File: rtl/term_link.sv
// Terminal glue: buffered keyboard-to-UART path with newline translation and a
// UART-to-display FIFO with optional local echo and saturating drop counters.
module term_link #(
    parameter int DISP_DEPTH_LOG2 = 4,
    parameter int KB_DEPTH_LOG2   = 2,
    parameter int DISP_BITS       = 7
) (
    input  logic                       clk_in,
    input  logic                       rst_n_in,
    input  logic [7:0]                 kb_data_in,
    input  logic                       kb_valid_in,
    output logic [7:0]                 tx_data_out,
    output logic                       tx_start_out,
    input  logic                       tx_ready_in,
    input  logic [7:0]                 rx_data_in,
    input  logic                       rx_valid_in,
    output logic [DISP_BITS-1:0]       disp_data_out,
    output logic                       disp_write_out,
    input  logic                       disp_ready_in,
    input  logic [1:0]                 mode_in,
    input  logic                       echo_in,
    output logic [DISP_DEPTH_LOG2:0]   disp_level_out,
    output logic [7:0]                 rx_drop_out,
    output logic [7:0]                 kb_drop_out
);

    localparam int DISP_DEPTH = 2 ** DISP_DEPTH_LOG2;
    localparam int KB_DEPTH   = 2 ** KB_DEPTH_LOG2;

    typedef enum logic [1:0] {IDLE, LF_PEND, HOLD} tx_state_e;

    logic [7:0]                 kb_mem [KB_DEPTH];
    logic [DISP_BITS-1:0]       dp_mem [DISP_DEPTH];

    logic [KB_DEPTH_LOG2:0]     kb_wr_q, kb_wr_d, kb_rd_q, kb_rd_d;
    logic [DISP_DEPTH_LOG2:0]   dp_wr_q, dp_wr_d, dp_rd_q, dp_rd_d;
    tx_state_e                  state_q, state_d;
    logic [7:0]                 tx_data_q, tx_data_d;
    logic                       tx_start_q, tx_start_d;
    logic [7:0]                 rx_drop_q, rx_drop_d;
    logic [7:0]                 kb_drop_q, kb_drop_d;

    logic                       kb_empty, kb_full, kb_push;
    logic                       dp_empty, dp_full, dp_push, dp_pop;
    logic [7:0]                 kb_head, tx_byte;
    logic [DISP_BITS-1:0]       dp_wdata;
    logic                       launch, lf_pair;
    logic                       unused_rx;

    assign unused_rx = ^rx_data_in;

    assign kb_empty = (kb_wr_q == kb_rd_q);
    assign kb_full  = (kb_wr_q[KB_DEPTH_LOG2] != kb_rd_q[KB_DEPTH_LOG2]) &&
                      (kb_wr_q[KB_DEPTH_LOG2-1:0] == kb_rd_q[KB_DEPTH_LOG2-1:0]);
    assign dp_empty = (dp_wr_q == dp_rd_q);
    assign dp_full  = (dp_wr_q[DISP_DEPTH_LOG2] != dp_rd_q[DISP_DEPTH_LOG2]) &&
                      (dp_wr_q[DISP_DEPTH_LOG2-1:0] == dp_rd_q[DISP_DEPTH_LOG2-1:0]);

    assign kb_head  = kb_mem[kb_rd_q[KB_DEPTH_LOG2-1:0]];
    assign kb_push  = kb_valid_in && !kb_full;

    // An echoing launch waits for a free display slot not claimed by the receiver.
    assign launch   = (state_q == IDLE) && tx_ready_in && !kb_empty &&
                      (!echo_in || (!dp_full && !rx_valid_in));
    assign lf_pair  = ((mode_in == 2'd2) && (kb_head == 8'h0A)) ||
                      ((mode_in == 2'd3) && (kb_head == 8'h0D));
    assign tx_byte  = (((mode_in == 2'd1) || (mode_in == 2'd2)) && (kb_head == 8'h0A)) ?
                      8'h0D : kb_head;

    assign dp_push  = rx_valid_in ? !dp_full : (launch && echo_in && !dp_full);
    assign dp_wdata = rx_valid_in ? rx_data_in[DISP_BITS-1:0] : kb_head[DISP_BITS-1:0];
    assign dp_pop   = disp_ready_in && !dp_empty;

    assign disp_write_out = dp_pop;
    assign disp_data_out  = dp_empty ? '0 : dp_mem[dp_rd_q[DISP_DEPTH_LOG2-1:0]];
    assign disp_level_out = dp_wr_q - dp_rd_q;
    assign tx_data_out    = tx_data_q;
    assign tx_start_out   = tx_start_q;
    assign rx_drop_out    = rx_drop_q;
    assign kb_drop_out    = kb_drop_q;

    always_comb begin
        // NOTE: every _d signal takes its hold value first, so no path leaves it unassigned (no latch).
        state_d    = state_q;
        tx_data_d  = tx_data_q;
        tx_start_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (launch) begin
                    tx_data_d  = tx_byte;
                    tx_start_d = 1'b1;
                    state_d    = lf_pair ? LF_PEND : HOLD;
                end
            end
            LF_PEND: begin
                // The first LF_PEND cycle is the launch strobe cycle; ready is ignored there.
                if (!tx_start_q && tx_ready_in) begin
                    tx_data_d  = 8'h0A;
                    tx_start_d = 1'b1;
                    state_d    = HOLD;
                end
            end
            HOLD:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        kb_wr_d   = kb_wr_q + (KB_DEPTH_LOG2 + 1)'(kb_push);
        kb_rd_d   = kb_rd_q + (KB_DEPTH_LOG2 + 1)'(launch);
        dp_wr_d   = dp_wr_q + (DISP_DEPTH_LOG2 + 1)'(dp_push);
        dp_rd_d   = dp_rd_q + (DISP_DEPTH_LOG2 + 1)'(dp_pop);
        rx_drop_d = (rx_valid_in && dp_full && (rx_drop_q != 8'hFF)) ? rx_drop_q + 8'd1 : rx_drop_q;
        kb_drop_d = (kb_valid_in && kb_full && (kb_drop_q != 8'hFF)) ? kb_drop_q + 8'd1 : kb_drop_q;
    end

    // NOTE: the storage arrays have no reset; pointers do, and an empty FIFO never exposes its contents.
    always_ff @(posedge clk_in) begin
        if (kb_push) kb_mem[kb_wr_q[KB_DEPTH_LOG2-1:0]] <= kb_data_in;
        if (dp_push) dp_mem[dp_wr_q[DISP_DEPTH_LOG2-1:0]] <= dp_wdata;
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n_in) begin
            state_q    <= IDLE;
            tx_data_q  <= '0;
            tx_start_q <= 1'b0;
            kb_wr_q    <= '0;
            kb_rd_q    <= '0;
            dp_wr_q    <= '0;
            dp_rd_q    <= '0;
            rx_drop_q  <= '0;
            kb_drop_q  <= '0;
        end else begin
            state_q    <= state_d;
            tx_data_q  <= tx_data_d;
            tx_start_q <= tx_start_d;
            kb_wr_q    <= kb_wr_d;
            kb_rd_q    <= kb_rd_d;
            dp_wr_q    <= dp_wr_d;
            dp_rd_q    <= dp_rd_d;
            rx_drop_q  <= rx_drop_d;
            kb_drop_q  <= kb_drop_d;
        end
    end

endmodule

// File: tb/tb_term_link.sv
// Bench for term_link: queue-based reference model and scoreboard checked on the
// falling edge, with directed scenarios followed by randomized traffic.
module tb_term_link;

    localparam int DL = 4;
    localparam int KL = 2;
    localparam int DB = 7;
    localparam int DD = 16;
    localparam int KD = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [7:0]    kb_data = '0;
    logic          kb_valid = 1'b0;
    logic [7:0]    tx_data_out;
    logic          tx_start_out;
    logic          tx_ready = 1'b1;
    logic [7:0]    rx_data = '0;
    logic          rx_valid = 1'b0;
    logic [DB-1:0] disp_data_out;
    logic          disp_write_out;
    logic          disp_ready = 1'b0;
    logic [1:0]    mode = '0;
    logic          echo = 1'b0;
    logic [DL:0]   disp_level_out;
    logic [7:0]    rx_drop_out;
    logic [7:0]    kb_drop_out;

    always #5 clk = ~clk;

    term_link #(.DISP_DEPTH_LOG2(DL), .KB_DEPTH_LOG2(KL), .DISP_BITS(DB)) dut (
        .clk_in(clk), .rst_n_in(rst_n),
        .kb_data_in(kb_data), .kb_valid_in(kb_valid),
        .tx_data_out(tx_data_out), .tx_start_out(tx_start_out), .tx_ready_in(tx_ready),
        .rx_data_in(rx_data), .rx_valid_in(rx_valid),
        .disp_data_out(disp_data_out), .disp_write_out(disp_write_out), .disp_ready_in(disp_ready),
        .mode_in(mode), .echo_in(echo),
        .disp_level_out(disp_level_out), .rx_drop_out(rx_drop_out), .kb_drop_out(kb_drop_out)
    );

    int checks = 0;
    int passes = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Reference model: expected transmit stream, display contents, keyboard occupancy.
    typedef struct { logic [7:0] data; bit first; logic [7:0] orig; } tx_exp_t;
    tx_exp_t        txq[$];
    logic [DB-1:0]  dq[$];
    int             kb_cnt = 0;
    int             rx_drop_m = 0;
    int             kb_drop_m = 0;
    int             last_strobe = -100;
    logic           p_kb_valid = 0, p_rx_valid = 0, p_disp_ready = 0, p_echo = 0;
    logic [7:0]     p_kb_data = 0, p_rx_data = 0;
    logic [1:0]     p_mode = 0;
    bit             mon_en = 0;

    function automatic void push_key(input logic [7:0] b, input logic [1:0] m);
        case (m)
            2'd0: txq.push_back('{data: b, first: 1'b1, orig: b});
            2'd1: txq.push_back('{data: (b == 8'h0A) ? 8'h0D : b, first: 1'b1, orig: b});
            2'd2: begin
                if (b == 8'h0A) begin
                    txq.push_back('{data: 8'h0D, first: 1'b1, orig: b});
                    txq.push_back('{data: 8'h0A, first: 1'b0, orig: b});
                end else txq.push_back('{data: b, first: 1'b1, orig: b});
            end
            default: begin
                txq.push_back('{data: b, first: 1'b1, orig: b});
                if (b == 8'h0D) txq.push_back('{data: 8'h0A, first: 1'b0, orig: b});
            end
        endcase
    endfunction

    function automatic void clear_model();
        txq.delete();
        dq.delete();
        kb_cnt = 0; rx_drop_m = 0; kb_drop_m = 0; last_strobe = -100;
        p_kb_valid = 0; p_rx_valid = 0; p_disp_ready = 0; p_echo = 0;
        p_kb_data = 0; p_rx_data = 0; p_mode = 0;
    endfunction

    // Monitor: observe cycle k, advance the model over cycle k-1, compare cycle k outputs.
    always @(negedge clk) begin
        if (mon_en) begin : mon
            logic       launch_prev;
            logic [7:0] echo_b;
            logic       dfull, kfull;
            tx_exp_t    e;
            launch_prev = 1'b0;
            echo_b = '0;
            if (tx_start_out) begin
                check("strobe_ready", tx_ready, 1);
                check("strobe_gap", (cyc - last_strobe) >= 2, 1);
                last_strobe = cyc;
                check("tx_expected", txq.size() != 0, 1);
                if (txq.size() != 0) begin
                    e = txq.pop_front();
                    check("tx_data", tx_data_out, e.data);
                    if (e.first) begin
                        launch_prev = 1'b1;
                        echo_b = e.orig;
                    end
                end
            end
            dfull = (dq.size() == DD);
            if (p_disp_ready && dq.size() > 0) void'(dq.pop_front());
            if (p_rx_valid) begin
                if (!dfull) dq.push_back(p_rx_data[DB-1:0]);
                else if (rx_drop_m < 255) rx_drop_m++;
            end
            if (launch_prev && p_echo) begin
                check("echo_slot", {p_rx_valid, dfull}, 0);
                if (!p_rx_valid && !dfull) dq.push_back(echo_b[DB-1:0]);
            end
            kfull = (kb_cnt == KD);
            if (launch_prev) begin
                check("kb_pop_nonempty", kb_cnt > 0, 1);
                if (kb_cnt > 0) kb_cnt--;
            end
            if (p_kb_valid) begin
                if (!kfull) begin
                    kb_cnt++;
                    push_key(p_kb_data, p_mode);
                end else if (kb_drop_m < 255) kb_drop_m++;
            end
            check("disp_level", disp_level_out, dq.size());
            check("disp_write", disp_write_out, disp_ready && (dq.size() > 0));
            if (dq.size() == 0) check("disp_data_empty", disp_data_out, 0);
            else if (disp_write_out) check("disp_data", disp_data_out, dq[0]);
            check("rx_drop", rx_drop_out, rx_drop_m);
            check("kb_drop", kb_drop_out, kb_drop_m);
            p_kb_valid = kb_valid; p_kb_data = kb_data; p_rx_valid = rx_valid;
            p_rx_data = rx_data; p_disp_ready = disp_ready; p_echo = echo; p_mode = mode;
        end
    end

    // UART model: ready drops the cycle after each strobe for a programmable time.
    int busy = 0;
    int busy_len = 0;
    bit busy_rand = 0;
    bit uart_stall = 0;
    bit strobe_last = 0;

    task automatic cycle();
        @(posedge clk);
        #1;
        if (strobe_last) busy = busy_rand ? int'($urandom_range(0, 4)) : busy_len;
        if (busy > 0) begin
            tx_ready = 1'b0;
            busy--;
        end else tx_ready = !uart_stall;
        strobe_last = tx_start_out;
        kb_valid = 1'b0;
        rx_valid = 1'b0;
    endtask

    task automatic reset_dut();
        mon_en = 0;
        #2 rst_n = 1'b0;
        kb_valid = 0; rx_valid = 0; disp_ready = 0;
        busy = 0; strobe_last = 0; uart_stall = 0; busy_rand = 0;
        #1;
        check("rst_tx_data", tx_data_out, 0);
        check("rst_tx_start", tx_start_out, 0);
        check("rst_disp_data", disp_data_out, 0);
        check("rst_disp_write", disp_write_out, 0);
        check("rst_disp_level", disp_level_out, 0);
        check("rst_rx_drop", rx_drop_out, 0);
        check("rst_kb_drop", kb_drop_out, 0);
        clear_model();
        cycle();
        cycle();
        rst_n = 1'b1;
        mon_en = 1;
    endtask

    task automatic drain(input string name);
        disp_ready = 1'b1;
        for (int i = 0; i < 400 && (txq.size() != 0 || kb_cnt != 0 || dq.size() != 0); i++) cycle();
        repeat (3) cycle();
        check({name, "_tx_empty"}, txq.size(), 0);
        check({name, "_disp_empty"}, disp_level_out, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        int c, s1, s2, s;
        logic [7:0] d1, d2;
        bit found;
        reset_dut();

        // T1: single key, mode 0, no echo.
        mode = 2'd0; echo = 1'b0; busy_len = 0;
        cycle();
        kb_data = 8'h41; kb_valid = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            cycle();
            check("t1_strobe", tx_start_out, i == 2);
            if (i == 2) check("t1_data", tx_data_out, 8'h41);
        end
        check("t1_no_echo", disp_level_out, 0);

        // T2: LF -> CR LF with the UART busy for 10 cycles after each strobe.
        mode = 2'd2; busy_len = 10;
        repeat (3) cycle();
        kb_data = 8'h0A; kb_valid = 1'b1;
        s1 = -1; s2 = -1; d1 = '0; d2 = '0;
        for (int i = 0; i < 40; i++) begin
            cycle();
            if (tx_start_out) begin
                if (s1 < 0) begin s1 = cyc; d1 = tx_data_out; end
                else if (s2 < 0) begin s2 = cyc; d2 = tx_data_out; end
            end
        end
        check("t2_first", d1, 8'h0D);
        check("t2_second", d2, 8'h0A);
        check("t2_gap", s2 - s1, 12);
        busy_len = 0;
        drain("t2");

        // T3: display overflow, then in-order drain one per cycle.
        mode = 2'd0; disp_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cycle();
            rx_data = 8'h30 + 8'(i); rx_valid = 1'b1;
        end
        cycle();
        check("t3_level", disp_level_out, 16);
        check("t3_rx_drop", rx_drop_out, 4);
        disp_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            #1;
            check("t3_write", disp_write_out, 1);
            check("t3_drain", disp_data_out, 7'h30 + 7'(i));
            cycle();
        end
        check("t3_empty", disp_level_out, 0);

        // T4: echo blocked one cycle by a receive write.
        echo = 1'b1; disp_ready = 1'b0;
        cycle();
        kb_data = 8'h62; kb_valid = 1'b1; c = cyc;
        cycle();
        rx_data = 8'h31; rx_valid = 1'b1;
        s = -1;
        for (int i = 0; i < 6; i++) begin
            cycle();
            if (tx_start_out && s < 0) s = cyc - c;
        end
        check("t4_delay", s, 3);
        check("t4_level", disp_level_out, 2);
        disp_ready = 1'b1;
        #1 check("t4_first", disp_data_out, 7'h31);
        cycle();
        #1 check("t4_second", disp_data_out, 7'h62);
        cycle();
        echo = 1'b0;

        // T5: keyboard overflow and counter saturation.
        uart_stall = 1'b1;
        repeat (3) cycle();
        for (int i = 0; i < 6; i++) begin
            cycle();
            kb_data = 8'h50 + 8'(i); kb_valid = 1'b1;
        end
        cycle();
        check("t5_drop", kb_drop_out, 2);
        for (int i = 0; i < 300; i++) begin
            cycle();
            kb_data = 8'h70; kb_valid = 1'b1;
        end
        cycle();
        check("t5_saturate", kb_drop_out, 255);
        uart_stall = 1'b0;
        drain("t5");

        // Randomized traffic under each mode and echo setting.
        for (int sub = 0; sub < 6; sub++) begin
            mode = 2'($urandom_range(0, 3));
            echo = 1'($urandom_range(0, 1));
            busy_rand = 1;
            for (int i = 0; i < 300; i++) begin
                cycle();
                kb_valid = ($urandom_range(0, 3) == 0);
                case ($urandom_range(0, 3))
                    0: kb_data = 8'h0A;
                    1: kb_data = 8'h0D;
                    default: kb_data = 8'($urandom_range(0, 255));
                endcase
                rx_valid = ($urandom_range(0, 2) == 0);
                rx_data = 8'($urandom_range(0, 255));
                disp_ready = 1'($urandom_range(0, 1));
            end
            drain("rand");
        end
        busy_rand = 0;

        // T6: reset while an LF is pending and the display is half full.
        reset_dut();
        mode = 2'd2; echo = 1'b0; busy_len = 10; disp_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            cycle();
            rx_data = 8'h40 + 8'(i); rx_valid = 1'b1;
        end
        cycle();
        kb_data = 8'h0A; kb_valid = 1'b1;
        found = 0;
        for (int i = 0; i < 10 && !found; i++) begin
            cycle();
            if (tx_start_out) found = 1;
        end
        check("t6_launch", found, 1);
        repeat (3) cycle();
        check("t6_half_full", disp_level_out, 8);
        reset_dut();
        busy_len = 0;
        s = 0;
        for (int i = 0; i < 20; i++) begin
            cycle();
            if (tx_start_out) s++;
        end
        check("t6_no_lf", s, 0);
        check("t6_empty", disp_level_out, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
